// File: rtl/axi_ic_pkg.sv
// Shared types and constants for the AXI interconnect write-channel control.
package axi_ic_pkg;

    // Write-channel ownership phases.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_ctrl_state_t;

    // Master identifiers as carried on sel / last_served.
    localparam logic MASTER0 = 1'b0;
    localparam logic MASTER1 = 1'b1;

endpackage : axi_ic_pkg

// File: rtl/write_channel_ctrl_rr_pick2.sv
// Combinational 2-way round-robin choice between master 0 and master 1.
module rr_pick2
    import axi_ic_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic pick
);

    // A lone requester wins; on contention the master not served last wins.
    always_comb begin
        pick = MASTER0;
        if (req0 && req1) begin
            pick = ~last_served;
        end else if (req1) begin
            pick = MASTER1;
        end
    end

endmodule : rr_pick2

// File: rtl/write_channel_ctrl.sv
// Write-channel ownership controller for a 2-master / 1-slave AXI interconnect.
// Optional RESP watchdog enabled by defining WRITE_CHANNEL_CTRL_TIMEOUT_EN.
module write_channel_ctrl
    import axi_ic_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic S00_AXI_awvalid,
    input  logic S01_AXI_awvalid,
    input  logic M_AXI_awvalid,
    input  logic M_AXI_awready,
    input  logic M_AXI_wvalid,
    input  logic M_AXI_wready,
    input  logic M_AXI_wlast,
    input  logic M_AXI_bvalid,
    input  logic M_AXI_bready,
    output logic sel,
    output logic aw_en,
    output logic w_en,
    output logic b_en,
    output logic busy
`ifdef WRITE_CHANNEL_CTRL_TIMEOUT_EN
    , output logic timeout_err
`endif
);

    // Reject configurations the watchdog counter cannot represent.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("write_channel_ctrl: TIMEOUT_CYCLES out of range 2..65535");
    end
    if (CNT_W < $clog2(TIMEOUT_CYCLES)) begin : g_bad_cnt_w
        $error("write_channel_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    wr_ctrl_state_t state_q, state_d;
    logic           sel_q, sel_d;
    logic           last_q, last_d;
    logic           aw_en_q, aw_en_d;
    logic           w_en_q, w_en_d;
    logic           b_en_q, b_en_d;
    logic           busy_q, busy_d;
    logic           pick;

`ifdef WRITE_CHANNEL_CTRL_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
`endif

    wire aw_hs = M_AXI_awvalid && M_AXI_awready;
    wire w_hs  = M_AXI_wvalid && M_AXI_wready;
    wire b_hs  = M_AXI_bvalid && M_AXI_bready;

    rr_pick2 u_pick (
        .req0        (S00_AXI_awvalid),
        .req1        (S01_AXI_awvalid),
        .last_served (last_q),
        .pick        (pick)
    );

    // Next-state, ownership and registered-output decode.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        aw_en_d = 1'b0;
        w_en_d  = 1'b0;
        b_en_d  = 1'b0;
        busy_d  = 1'b0;
`ifdef WRITE_CHANNEL_CTRL_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (S00_AXI_awvalid || S01_AXI_awvalid) begin
                    state_d = ADDR;
                    sel_d   = pick;
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_hs && M_AXI_wlast) begin
                    state_d = RESP;
`ifdef WRITE_CHANNEL_CTRL_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                end
`ifdef WRITE_CHANNEL_CTRL_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2)) begin
                    // Counter would reach TIMEOUT_CYCLES-1: abandon the slave.
                    state_d = IDLE;
                    last_d  = sel_q;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        aw_en_d = (state_d == ADDR);
        w_en_d  = (state_d == DATA);
        b_en_d  = (state_d == RESP);
        busy_d  = (state_d != IDLE);
    end

    // State and registered outputs; reset drops ownership and favours M0.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            sel_q   <= MASTER0;
            last_q  <= MASTER1;
            aw_en_q <= 1'b0;
            w_en_q  <= 1'b0;
            b_en_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef WRITE_CHANNEL_CTRL_TIMEOUT_EN
            cnt_q   <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            aw_en_q <= aw_en_d;
            w_en_q  <= w_en_d;
            b_en_q  <= b_en_d;
            busy_q  <= busy_d;
`ifdef WRITE_CHANNEL_CTRL_TIMEOUT_EN
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
`endif
        end
    end

    assign sel   = sel_q;
    assign aw_en = aw_en_q;
    assign w_en  = w_en_q;
    assign b_en  = b_en_q;
    assign busy  = busy_q;
`ifdef WRITE_CHANNEL_CTRL_TIMEOUT_EN
    assign timeout_err = terr_q;
`endif

endmodule : write_channel_ctrl

// File: tb/tb_write_channel_ctrl.sv
// Scoreboard bench for write_channel_ctrl; grants are predicted by a
// transaction-level round-robin model and checked by an independent monitor.
module tb_write_channel_ctrl;

    localparam int unsigned TO = 8;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    logic S00_AXI_awvalid = 1'b0, S01_AXI_awvalid = 1'b0;
    logic M_AXI_awvalid = 1'b0, M_AXI_awready = 1'b0;
    logic M_AXI_wvalid = 1'b0, M_AXI_wready = 1'b0, M_AXI_wlast = 1'b0;
    logic M_AXI_bvalid = 1'b0, M_AXI_bready = 1'b0;
    logic sel, aw_en, w_en, b_en, busy;
`ifdef WRITE_CHANNEL_CTRL_TIMEOUT_EN
    logic timeout_err;
`endif

    write_channel_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .S00_AXI_awvalid (S00_AXI_awvalid),
        .S01_AXI_awvalid (S01_AXI_awvalid),
        .M_AXI_awvalid   (M_AXI_awvalid),
        .M_AXI_awready   (M_AXI_awready),
        .M_AXI_wvalid    (M_AXI_wvalid),
        .M_AXI_wready    (M_AXI_wready),
        .M_AXI_wlast     (M_AXI_wlast),
        .M_AXI_bvalid    (M_AXI_bvalid),
        .M_AXI_bready    (M_AXI_bready),
        .sel             (sel),
        .aw_en           (aw_en),
        .w_en            (w_en),
        .b_en            (b_en),
        .busy            (busy)
`ifdef WRITE_CHANNEL_CTRL_TIMEOUT_EN
        , .timeout_err   (timeout_err)
`endif
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];      // expected owner of each upcoming grant
    bit model_last;    // master that most recently finished (model view)

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference arbitration: lone requester wins, else whoever was not served last.
    function automatic bit model_pick(input bit r0, input bit r1, input bit last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Monitor: every new grant must match the scoreboard head.
    logic aw_prev = 1'b0;
    always @(negedge ACLK) begin
        bit e;
        if (aw_en === 1'b1 && aw_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("grant_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("grant_sel", 32'(sel), 32'(e));
            end
        end
        chk("enables_vs_busy", 32'(aw_en) + 32'(w_en) + 32'(b_en), 32'(busy));
        aw_prev = aw_en;
    end

    // One transaction from IDLE. mode: 0 normal B, 1 watchdog abort,
    // 2 B in the last watchdog cycle, 3 reset pulse while in RESP.
    task automatic run_txn(input bit r0, input bit r1, input bit m0, input bit m1,
                           input bit early_w, input int aw_dly, input int nbeats,
                           input int stall_beat, input int stall_len,
                           input int b_dly, input int mode);
        bit exp;
        exp = model_pick(r0, r1, model_last);
        S00_AXI_awvalid = r0;
        S01_AXI_awvalid = r1;
        exp_q.push_back(exp);
        tick();
        chk("aw_en_after_req", 32'(aw_en), 32'd1);
        chk("busy_after_req", 32'(busy), 32'd1);
        S00_AXI_awvalid = m0;
        S01_AXI_awvalid = m1;
        M_AXI_wvalid = early_w;
        M_AXI_wready = early_w;
        repeat (aw_dly) begin
            tick();
            chk("addr_hold", 32'(aw_en), 32'd1);
            chk("w_early_blocked", 32'(w_en), 32'd0);
        end
        M_AXI_awvalid = 1'b1;
        M_AXI_awready = 1'b1;
        tick();
        M_AXI_awvalid = 1'b0;
        M_AXI_awready = 1'b0;
        M_AXI_wvalid = 1'b0;
        M_AXI_wready = 1'b0;
        chk("data_entry_w_en", 32'(w_en), 32'd1);
        chk("data_entry_aw_en", 32'(aw_en), 32'd0);
        for (int b = 0; b < nbeats; b++) begin
            M_AXI_wvalid = 1'b1;
            M_AXI_wlast = (b == nbeats - 1);
            if (b == stall_beat) begin
                M_AXI_wready = 1'b0;
                repeat (stall_len) begin
                    tick();
                    chk("w_stall_hold", 32'(w_en), 32'd1);
                end
            end
            M_AXI_wready = 1'b1;
            tick();
            if (b < nbeats - 1) chk("w_beat_hold", 32'(w_en), 32'd1);
            else chk("resp_entry", 32'(b_en), 32'd1);
        end
        M_AXI_wvalid = 1'b0;
        M_AXI_wready = 1'b0;
        M_AXI_wlast = 1'b0;
        if (mode == 3) begin
            ARESETN = 1'b0;
            #1;
            chk("rst_sel", 32'(sel), 32'd0);
            chk("rst_aw_en", 32'(aw_en), 32'd0);
            chk("rst_w_en", 32'(w_en), 32'd0);
            chk("rst_b_en", 32'(b_en), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            model_last = 1'b1;
            S00_AXI_awvalid = 1'b0;
            S01_AXI_awvalid = 1'b0;
            tick();
            ARESETN = 1'b1;
            return;
        end
`ifdef WRITE_CHANNEL_CTRL_TIMEOUT_EN
        if (mode == 1 || mode == 2) begin
            repeat (TO - 2) begin
                tick();
                chk("wd_resp_hold", 32'(b_en), 32'd1);
                chk("wd_no_err", 32'(timeout_err), 32'd0);
            end
            if (mode == 2) begin
                M_AXI_bvalid = 1'b1;
                M_AXI_bready = 1'b1;
            end
            tick();
            M_AXI_bvalid = 1'b0;
            M_AXI_bready = 1'b0;
            chk("wd_pulse", 32'(timeout_err), (mode == 1) ? 32'd1 : 32'd0);
            chk("wd_idle", 32'(busy), 32'd0);
            S00_AXI_awvalid = 1'b0;
            S01_AXI_awvalid = 1'b0;
            tick();
            chk("wd_pulse_end", 32'(timeout_err), 32'd0);
            model_last = exp;
            return;
        end
`endif
        M_AXI_bready = 1'($urandom_range(0, 1));
        repeat (b_dly) begin
            tick();
            chk("b_wait", 32'(b_en), 32'd1);
        end
        M_AXI_bvalid = 1'b1;
        M_AXI_bready = 1'b1;
        tick();
        M_AXI_bvalid = 1'b0;
        M_AXI_bready = 1'b0;
        chk("b_done_busy", 32'(busy), 32'd0);
        chk("b_done_b_en", 32'(b_en), 32'd0);
        model_last = exp;
    endtask

    initial begin
        int r, g;
        model_last = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_aw_en", 32'(aw_en), 32'd0);
        chk("reset_w_en", 32'(w_en), 32'd0);
        chk("reset_b_en", 32'(b_en), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        ARESETN = 1'b1;
        tick();

        // Continuous contention alternates starting with M0.
        repeat (4) run_txn(1, 1, 1, 1, 0, 1, 2, -1, 0, 1, 0);
        // 4-beat burst stalled two cycles on beat 3, with early W before DATA.
        run_txn(1, 0, 0, 0, 1, 2, 4, 2, 2, 0, 0);
        // M1 request shows up mid-transaction; granted only after completion.
        run_txn(1, 0, 0, 1, 0, 1, 3, -1, 0, 2, 0);
        run_txn(0, 1, 0, 0, 0, 0, 1, -1, 0, 0, 0);
        // Request dropping during ADDR does not abort.
        run_txn(0, 1, 0, 0, 0, 3, 2, 0, 1, 1, 0);
        // Reset during RESP, then contention must go to M0.
        run_txn(0, 1, 1, 1, 0, 0, 2, -1, 0, 0, 3);
        run_txn(1, 1, 0, 0, 0, 0, 1, -1, 0, 0, 0);
`ifdef WRITE_CHANNEL_CTRL_TIMEOUT_EN
        run_txn(1, 1, 0, 0, 0, 0, 1, -1, 0, 0, 1);
        run_txn(1, 1, 0, 0, 0, 0, 1, -1, 0, 0, 2);
        run_txn(1, 1, 0, 0, 0, 0, 1, -1, 0, 0, 0);
`endif

        // Randomized traffic against the model.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                S00_AXI_awvalid = 1'b0;
                S01_AXI_awvalid = 1'b0;
                g = int'($urandom_range(1, 3));
                repeat (g) begin
                    tick();
                    chk("idle_no_req", 32'(busy), 32'd0);
                end
            end
            r = int'($urandom_range(1, 3));
            run_txn(1'(r), 1'(r >> 1),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(1, 5)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 0);
        end

        S00_AXI_awvalid = 1'b0;
        S01_AXI_awvalid = 1'b0;
        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_write_channel_ctrl
